// File: rtl/pipecleaner_input_stage.sv
// pipecleaner_input_stage: front end of the Pipecleaner core.
// Synchronises ui_in, optionally debounces the button lines ui_in[3:0],
// turns button rising edges into {btn_idx, nibble} events and queues them
// in a small FIFO drained over a valid/ready port.
// Optional feature macro: PIPECLEANER_DEBOUNCE_EN (per-button debounce counters).
//
// Handshake: evt_valid is high whenever the FIFO holds an entry and evt_data
// shows that entry; the head is consumed on a clock edge where
// evt_valid && evt_ready. evt_data holds while evt_ready is low, and
// evt_ready is ignored while evt_valid is low.
`timescale 1ns/1ps

module pipecleaner_input_stage #(
    parameter int DEPTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [7:0]                 ui_in,
    output logic [5:0]                 evt_data,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]        s1_q, s2_q;
    logic [3:0]        db;
    logic [3:0]        db_prev_q;
    logic [3:0]        rise;
    logic [3:0]        pend_q, pend_d;
    logic [3:0][3:0]   nib_q, nib_d;
    logic [5:0]        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              sel_valid;
    logic [1:0]        sel_idx;
    logic              empty, full, pop, push, drop;

    // Two-flop synchroniser for all inputs, free-running regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= ui_in;
            s2_q <= s1_q;
        end
    end

`ifdef PIPECLEANER_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);

    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         db_q, db_d;

    // Debounce: count while the synchronised line disagrees with the
    // debounced state; flip the state once the disagreement has lasted DB_CYCLES edges.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_d[i]  = ~db_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db = db_q;
`else
    assign db = s2_q[3:0];
`endif

    assign rise  = db & ~db_prev_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && evt_ready;

    // Pick the lowest pending button; at most one push per cycle.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(i);
            end
        end
    end

    // Next state for pending mask, nibbles, pointers and overflow flag.
    // A new rise on the selected button re-arms it, so set wins over clear.
    always_comb begin
        push     = sel_valid && (!full || pop);
        drop     = sel_valid && full && !pop;
        pend_d   = pend_q;
        nib_d    = nib_q;
        if (sel_valid) begin
            pend_d[sel_idx] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (ena && rise[i]) begin
                pend_d[i] = 1'b1;
                nib_d[i]  = s2_q[7:4];
            end
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Event capture, FIFO storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_q <= '0;
            pend_q    <= '0;
            nib_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            db_prev_q <= db;
            pend_q    <= pend_d;
            nib_q     <= nib_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {sel_idx, nib_q[sel_idx]};
            end
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipecleaner_input_stage.sv
// Testbench for pipecleaner_input_stage: directed scenarios followed by a
// randomized phase, every cycle compared against a queue-based event model.
`timescale 1ns/1ps

module tb_pipecleaner_input_stage;

    localparam int DEPTH     = 4;
    localparam int DB_CYCLES = 16;
`ifdef PIPECLEANER_DEBOUNCE_EN
    localparam int DB_LAT = DB_CYCLES;
    localparam bit DB_ON  = 1'b1;
`else
    localparam int DB_LAT = 0;
    localparam bit DB_ON  = 1'b0;
`endif
    localparam int SETTLE = DB_LAT + 10;

    // ---------------- clock / reset / DUT ----------------
    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ena       = 1'b0;
    logic [7:0] ui_in     = 8'h00;
    logic       evt_ready = 1'b0;
    logic       clr_ovf   = 1'b0;
    logic [5:0] evt_data;
    logic       evt_valid;
    logic [2:0] level;
    logic       ovf;

    always #5 clk = ~clk;

    pipecleaner_input_stage #(.DEPTH(DEPTH), .DB_CYCLES(DB_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .ui_in     (ui_in),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];     // events the DUT should be holding, head first
    logic [7:0] m_s1, m_s2;   // synchronised view of ui_in
    logic [3:0] m_db;         // debounced buttons (debounce build)
    int         m_run[4];     // consecutive cycles the line disagreed with m_db
    logic [3:0] m_seen;       // button state seen on the previous cycle
    logic [3:0] m_pend;       // buttons with an event waiting to enter the FIFO
    logic [3:0] m_nib[4];
    bit         m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_seen = '0; m_pend = '0; m_ovf = 0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_nib[i] = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        logic [3:0] btn, rise, new_pend;
        bit         was_full, pop, drop;
        int         sel;
        if (!rst_n) begin
            model_reset();
            return;
        end
        btn      = DB_ON ? m_db : m_s2[3:0];
        rise     = btn & ~m_seen;
        was_full = (exp_q.size() == DEPTH);
        pop      = (exp_q.size() != 0) && evt_ready;
        drop     = 0;
        new_pend = m_pend;
        sel      = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && sel < 0) sel = i;
        if (pop) void'(exp_q.pop_front());
        if (sel >= 0) begin
            new_pend[sel] = 1'b0;
            if (was_full && !pop) drop = 1;
            else exp_q.push_back({2'(sel), m_nib[sel]});
        end
        if (ena) begin
            for (int i = 0; i < 4; i++) begin
                if (rise[i]) begin
                    new_pend[i] = 1'b1;
                    m_nib[i]    = m_s2[7:4];
                end
            end
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        if (DB_ON) begin
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_CYCLES) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_pend = new_pend;
        m_seen = btn;
        m_s2   = m_s1;
        m_s1   = ui_in;
    endtask

    task automatic compare_all();
        check("valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        check("level", 32'(level), 32'(exp_q.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (exp_q.size() != 0) check("data", 32'(evt_data), 32'(exp_q[0]));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model follows the edge, DUT is sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!evt_valid && lat < 60);
    endtask

    // ---------------- stimulus ----------------
    int         lat;
    int         waited;
    logic [5:0] drain_exp [4];

    initial begin
        model_reset();

        // T1: reset with all buttons high.
        ui_in = 8'hFF;
        rst_n = 1'b0;
        #2;
        check("t1_rst_valid", 32'(evt_valid), 32'd0);
        check("t1_rst_level", 32'(level), 32'd0);
        check("t1_rst_ovf", 32'(ovf), 32'd0);
        check("t1_rst_data", 32'(evt_data), 32'd0);
        hold(2);
        rst_n = 1'b1;
        hold(3);
        check("t1_idle_level", 32'(level), 32'd0);
        ui_in = 8'h00;
        hold(SETTLE);
        ena = 1'b1;

        // T2: single press, latency and data.
        ui_in = 8'hA2;
        measure_latency(lat);
        check("t2_latency", 32'(lat), 32'(4 + DB_LAT));
        check("t2_data", 32'(evt_data), 32'b01_1010);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("t2_level_after_pop", 32'(level), 32'd0);
        ui_in = 8'h00;
        hold(SETTLE);

        // T3: four simultaneous presses, then overflow and clear.
        ui_in = 8'h5F;
        hold(SETTLE);
        check("t3_level", 32'(level), 32'd4);
        check("t3_head", 32'(evt_data), 32'h05);
        ui_in = 8'h00;
        hold(SETTLE);
        ui_in = 8'h51;
        hold(SETTLE);
        check("t3_ovf_set", 32'(ovf), 32'd1);
        check("t3_level_full", 32'(level), 32'd4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'd0);

        // T4: pop in the same cycle a push lands on a full FIFO.
        ui_in = 8'h00;
        hold(SETTLE);
        ui_in  = 8'h51;
        waited = 0;
        while (m_pend == 4'b0 && waited < 60) begin
            step();
            waited++;
        end
        check("t4_pend_seen", 32'(waited < 60), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("t4_level", 32'(level), 32'd4);
        check("t4_ovf", 32'(ovf), 32'd0);
        drain_exp[0] = 6'h15;
        drain_exp[1] = 6'h25;
        drain_exp[2] = 6'h35;
        drain_exp[3] = 6'h05;
        for (int k = 0; k < 4; k++) begin
            check("t4_order", 32'(evt_data), 32'(drain_exp[k]));
            evt_ready = 1'b1;
            step();
        end
        evt_ready = 1'b0;
        check("t4_drained", 32'(level), 32'd0);
        ui_in = 8'h00;
        hold(SETTLE);

`ifdef PIPECLEANER_DEBOUNCE_EN
        // T5: glitch rejection and debounced latency.
        ui_in = 8'h02;
        hold(10);
        ui_in = 8'h00;
        hold(30);
        check("t5_glitch", 32'(level), 32'd0);
        ui_in = 8'h02;
        measure_latency(lat);
        check("t5_latency", 32'(lat), 32'd20);
        check("t5_data", 32'(evt_data), 32'h10);
        hold(10);
        ui_in = 8'h00;
        hold(SETTLE);
        check("t5_one_event", 32'(level), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
`endif

        // T6: rise while disabled is lost; async reset clears a partly full FIFO.
        ena   = 1'b0;
        ui_in = 8'h01;
        hold(SETTLE);
        ena = 1'b1;
        hold(SETTLE);
        check("t6_ena_low", 32'(level), 32'd0);
        ui_in = 8'h00;
        hold(SETTLE);
        ui_in = 8'h37;
        hold(SETTLE);
        check("t6_level3", 32'(level), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t6_async_level", 32'(level), 32'd0);
        check("t6_async_valid", 32'(evt_valid), 32'd0);
        model_reset();
        ui_in = 8'h00;
        hold(2);
        rst_n = 1'b1;
        hold(SETTLE);

        // Randomized phase: free-running buttons, ready, ena and clr_ovf.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) ui_in = 8'($urandom);
            if (n < 300) evt_ready = ($urandom_range(0, 2) != 0);
            else         evt_ready = ($urandom_range(0, 3) == 0);
            ena     = ($urandom_range(0, 7) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
